// File: rtl/tx_polyphase.sv
// tx_polyphase: multiplier-free polyphase pulse-shaping FIR for one QPSK rail.
module tx_polyphase #(
  parameter int NBAUDS = 6,
  parameter int OVERSAMPLE = 4,
  parameter int COEF_NBITS = 8,
  parameter int COEF_FBITS = 7,
  parameter logic [NBAUDS*OVERSAMPLE*COEF_NBITS-1:0] COEF = '0,
  parameter int OUT_NBITS = 8,
  parameter int OUT_FBITS = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sym_in,
  output logic                 sym_ready,
  output logic [OUT_NBITS-1:0] tx_out,
  output logic                 tx_valid
);
  localparam int NCOEF = NBAUDS*OVERSAMPLE;
  localparam int ACC_NBITS = COEF_NBITS + $clog2(NBAUDS) + 1;
  localparam int PH_NBITS = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_NBITS = NCOEF > 1 ? $clog2(NCOEF) : 1;
  localparam int LO = COEF_FBITS - OUT_FBITS;
  localparam int HI = LO + OUT_NBITS - 1;
  logic [PH_NBITS-1:0] phase;
  logic [NBAUDS-1:0] sbuf, vbuf, sbuf_n, vbuf_n;
  logic signed [COEF_NBITS-1:0] h [NCOEF];
  logic signed [ACC_NBITS-1:0] acc, tap_x;
  logic [IDX_NBITS-1:0] idx;
  logic [ACC_NBITS-1-HI:0] top;
  logic [OUT_NBITS-1:0] sat;
  for (genvar g = 0; g < NCOEF; g++) begin : g_tap
    assign h[g] = COEF[NCOEF*COEF_NBITS-1-g*COEF_NBITS -: COEF_NBITS];
  end
  assign sym_ready = enable && phase == '0;
  assign sbuf_n = sym_ready ? {sbuf[NBAUDS-2:0], sym_in} : sbuf;
  assign vbuf_n = sym_ready ? {vbuf[NBAUDS-2:0], 1'b1} : vbuf;
  // Symbol j sees tap j*OVERSAMPLE+phase; empty history slots add nothing.
  always_comb begin
    acc = '0;
    idx = '0;
    tap_x = '0;
    for (int j = 0; j < NBAUDS; j++) begin
      idx = IDX_NBITS'(j*OVERSAMPLE) + IDX_NBITS'(phase);
      tap_x = ACC_NBITS'(h[idx]);
      acc = acc + (vbuf_n[j] ? (sbuf_n[j] ? -tap_x : tap_x) : '0);
    end
  end
  assign top = acc[ACC_NBITS-1:HI];
  assign sat = (&top || ~|top) ? acc[HI:LO]
             : acc[ACC_NBITS-1] ? {1'b1, {(OUT_NBITS-1){1'b0}}} : {1'b0, {(OUT_NBITS-1){1'b1}}};
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      sbuf <= '0;
      vbuf <= '0;
      tx_out <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= enable;
      if (enable) begin
        phase <= phase == PH_NBITS'(OVERSAMPLE-1) ? '0 : phase + 1'b1;
        sbuf <= sbuf_n;
        vbuf <= vbuf_n;
        tx_out <= sat;
      end
    end
  end
endmodule

// File: tb/tb_tx_polyphase.sv
// tb_tx_polyphase: randomized scoreboard bench against a symbol-list model of the shaping filter.
module tb_tx_polyphase;
  localparam logic [191:0] COEF = 192'h7F8040C07F10F0007F33CD017FFF20E07F55AB087F807F02;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sym_in = 1'b0;
  logic sym_ready, tx_valid;
  logic [7:0] tx_out;
  typedef struct {logic v; logic [7:0] d;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int h[24];
  int syms[$];
  int ph = 0;
  logic [7:0] last = '0;
  logic cur = 1'b0;
  tx_polyphase #(.COEF(COEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sym_in(sym_in),
    .sym_ready(sym_ready), .tx_out(tx_out), .tx_valid(tx_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input logic s);
    int acc;
    reset = r;
    enable = e;
    sym_in = s;
    #1;
    vectors++;
    if (sym_ready !== (e && ph == 0)) begin
      miscompares++;
      $display("FAIL sym_ready t=%0t got %b want %b", $time, sym_ready, e && ph == 0);
    end
    if (r) begin
      syms.delete();
      ph = 0;
      last = '0;
      q.push_back('{1'b0, 8'h00});
    end else if (e) begin
      if (ph == 0) begin
        syms.push_front(s ? -1 : 1);
        if (syms.size() > 6) void'(syms.pop_back());
      end
      acc = 0;
      foreach (syms[j]) acc += syms[j] * h[j*4+ph];
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      last = 8'(acc);
      q.push_back('{1'b1, last});
      ph = (ph + 1) % 4;
    end else begin
      q.push_back('{1'b0, last});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (tx_valid !== x.v || tx_out !== x.d) begin
          miscompares++;
          $display("FAIL tx_out t=%0t got v=%b d=%h want v=%b d=%h", $time, tx_valid, tx_out, x.v, x.d);
        end
      end
    end
  end
  initial begin
    logic [191:0] cv;
    cv = COEF;
    for (int k = 0; k < 24; k++) h[k] = int'($signed(cv[191-8*k -: 8]));
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 8 && ph != 2; n++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) cur = ~cur;
      step(1'($urandom_range(80) == 0), 1'($urandom_range(1)), cur);
    end
    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
